// File: rtl/mprj_wb_pkg.sv
// Shared constants for the user-project wishbone responder: register offsets,
// CTRL/STATUS bit positions, bus widths and a byte-lane merge helper.
package mprj_wb_pkg;

    localparam int DATA_W  = 32;
    localparam int MATCH_W = 24;

    // Word indices (adr[7:2]) of the mapped registers
    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_FIFO    = 6'h02;
    localparam logic [5:0] OFF_RELOAD  = 6'h03;
    localparam logic [5:0] OFF_COUNT   = 6'h04;
    localparam logic [5:0] OFF_SCRATCH = 6'h05;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_TIRQ_EN  = 1;
    localparam int CTRL_FIRQ_EN  = 2;
    localparam int CTRL_EIRQ_EN  = 3;
    localparam int CTRL_FIFO_CLR = 4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_TPEND     = 9;
    localparam int ST_OVF       = 10;
    localparam int ST_UDF       = 11;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] wdata,
        input logic [3:0]        sel
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mprj_wb_fifo.sv
// Show-ahead synchronous FIFO; pushes when full and pops when empty are ignored
// (the caller flags them). clr empties it without touching stored data.
module mprj_wb_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push & ~full & ~rst & ~clr;
    assign do_pop  = pop & ~empty & ~rst & ~clr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mprj_wb_responder.sv
// Wishbone classic responder: CTRL/STATUS/SCRATCH, loopback FIFO, user IRQs.
// Define MPRJ_WB_TIMER_EN to build the reload timer (RELOAD, COUNT, timer_pend).
module mprj_wb_responder
    import mprj_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  user_irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              hit, wr_en, rd_en, w1c, ctrl_wr;
    logic [5:0]        widx;
    logic [DATA_W-1:0] rdata, scratch, fifo_dout;
    logic [2:0]        irq_en;
    logic              ovf, udf;
    logic              fifo_push, fifo_pop, fifo_clr, fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              timer_en_rd, pend_rd;
    logic [DATA_W-1:0] reload_rd, count_rd;
    logic              unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

    // ~ack keeps a held strobe from being taken twice
    assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                 (wbs_adr_i[31 -: MATCH_W] == BASE_ADDR[31 -: MATCH_W]);
    assign widx  = wbs_adr_i[7:2];
    assign wr_en = hit & wbs_we_i;
    assign rd_en = hit & ~wbs_we_i;
    assign w1c   = wr_en & (widx == OFF_STATUS);
    assign ctrl_wr   = wr_en & (widx == OFF_CTRL) & wbs_sel_i[0];
    assign fifo_push = wr_en & (widx == OFF_FIFO);
    assign fifo_pop  = rd_en & (widx == OFF_FIFO);
    assign fifo_clr  = ctrl_wr & wbs_dat_i[CTRL_FIFO_CLR];

    mprj_wb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .din   (wbs_dat_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en  <= '0;
            scratch <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_EIRQ_EN:CTRL_TIRQ_EN];
            if (wr_en && widx == OFF_SCRATCH)
                scratch <= byte_merge(scratch, wbs_dat_i, wbs_sel_i);
            ovf <= (ovf & ~(w1c & wbs_dat_i[ST_OVF])) | (fifo_push & fifo_full);
            udf <= (udf & ~(w1c & wbs_dat_i[ST_UDF])) | (fifo_pop & fifo_empty);
        end
    end

`ifdef MPRJ_WB_TIMER_EN
    logic              timer_en, pend;
    logic [DATA_W-1:0] reload, count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            timer_en <= 1'b0;
            pend     <= 1'b0;
            reload   <= '0;
            count    <= '0;
        end else begin
            if (ctrl_wr) timer_en <= wbs_dat_i[CTRL_TIMER_EN];
            // A RELOAD write restarts the count from the new value
            if (wr_en && widx == OFF_RELOAD) begin
                reload <= byte_merge(reload, wbs_dat_i, wbs_sel_i);
                count  <= byte_merge(reload, wbs_dat_i, wbs_sel_i);
            end else if (timer_en) begin
                count <= (count == '0) ? reload : count - DATA_W'(1);
            end
            pend <= (pend & ~(w1c & wbs_dat_i[ST_TPEND])) | (timer_en & (count == '0));
        end
    end

    assign timer_en_rd = timer_en;
    assign pend_rd     = pend;
    assign reload_rd   = reload;
    assign count_rd    = count;
`else
    assign timer_en_rd = 1'b0;
    assign pend_rd     = 1'b0;
    assign reload_rd   = '0;
    assign count_rd    = '0;
`endif

    always_comb begin
        rdata = '0;
        case (widx)
            OFF_CTRL:    rdata[CTRL_EIRQ_EN:CTRL_TIMER_EN] = {irq_en, timer_en_rd};
            OFF_STATUS: begin
                rdata[ST_EMPTY]             = fifo_empty;
                rdata[ST_FULL]              = fifo_full;
                rdata[ST_COUNT_LSB +: 5]    = 5'(fifo_count);
                rdata[ST_TPEND]             = pend_rd;
                rdata[ST_OVF]               = ovf;
                rdata[ST_UDF]               = udf;
            end
            OFF_FIFO:    rdata = fifo_empty ? '0 : fifo_dout;
            OFF_RELOAD:  rdata = reload_rd;
            OFF_COUNT:   rdata = count_rd;
            OFF_SCRATCH: rdata = scratch;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            user_irq  <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= rd_en ? rdata : '0;
            user_irq  <= {(ovf | udf) & irq_en[2], ~fifo_empty & irq_en[1], pend_rd & irq_en[0]};
        end
    end

endmodule
